// File: rtl/bsg_priority_encode_pkg.sv
// Shared definitions for the priority-encode / arbiter family.
// Only the search-direction enum lives here; the round-robin encoder keys on lo_to_hi_p.
package bsg_priority_encode_pkg;

  typedef enum logic [0:0] {
    e_lo_to_hi = 1'b0,
    e_hi_to_lo = 1'b1
  } encode_dir_e;

endpackage

// File: rtl/bsg_priority_encode_rr_if.sv
// Request / grant bundle between a requester bank, the round-robin encoder and its consumer.
// The encoder side is the slave: it takes requests and yumi, and returns taken and the held grant.
interface bsg_priority_encode_rr_if
  import bsg_priority_encode_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int lg_width_lp = (width_p == 1) ? 1 : $clog2(width_p)
);

  logic [width_p-1:0]     reqs_i;
  logic [width_p-1:0]     taken_o;
  logic                   v_o;
  logic [lg_width_lp-1:0] addr_o;
  logic [width_p-1:0]     one_hot_o;
  logic                   yumi_i;

  modport master (
    output reqs_i, yumi_i,
    input  taken_o, v_o, addr_o, one_hot_o
  );

  modport slave (
    input  reqs_i, yumi_i,
    output taken_o, v_o, addr_o, one_hot_o
  );

endinterface

// File: rtl/bsg_priority_encode_dir.sv
// Combinational first-set finder: one-hot, index and any-set flag of the first
// set bit, scanning upward (lo_to_hi_p=1) or downward (lo_to_hi_p=0).
module bsg_priority_encode_dir
  import bsg_priority_encode_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int lo_to_hi_p  = 1,
  parameter int lg_width_lp = (width_p == 1) ? 1 : $clog2(width_p)
) (
  input  logic [width_p-1:0]     vec,
  output logic [width_p-1:0]     one_hot,
  output logic [lg_width_lp-1:0] addr,
  output logic                   v
);

  logic [width_p-1:0] ordered_s;
  logic [width_p-1:0] isolated_s;

  // Reorder so the first bit in search order is bit 0, isolate it with x & -x, then undo the order.
  always_comb begin
    ordered_s  = {width_p{1'b0}};
    one_hot    = {width_p{1'b0}};
    addr       = {lg_width_lp{1'b0}};
    for (int i = 0; i < width_p; i++) begin
      ordered_s[i] = (lo_to_hi_p != 0) ? vec[i] : vec[width_p-1-i];
    end
    isolated_s = ordered_s & (~ordered_s + width_p'(1'b1));
    for (int i = 0; i < width_p; i++) begin
      one_hot[i] = (lo_to_hi_p != 0) ? isolated_s[i] : isolated_s[width_p-1-i];
    end
    for (int i = 0; i < width_p; i++) begin
      addr = addr | ({lg_width_lp{one_hot[i]}} & lg_width_lp'(i));
    end
    v = |vec;
  end

endmodule

// File: rtl/bsg_priority_encode_rr_chk.sv
// Simulation-time protocol checks for the round-robin encoder handshake.
module bsg_priority_encode_rr_chk #(
  parameter int width_p = 32
) (
  input logic               clk,
  input logic               reset,
  input logic [width_p-1:0] reqs,
  input logic [width_p-1:0] taken,
  input logic               v,
  input logic               yumi
);

  yumi_needs_grant: assert property (@(posedge clk) disable iff (reset) !(yumi && !v));

  taken_is_requested: assert property (@(posedge clk) disable iff (reset)
    ((taken & ~reqs) == {width_p{1'b0}}));

endmodule

// File: rtl/bsg_priority_encode_rr.sv
// Registered priority encoder with optional round-robin start pointer.
// One winner per cycle is acknowledged on taken_o and held in the output register until yumi.
module bsg_priority_encode_rr
  import bsg_priority_encode_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int lo_to_hi_p  = 1,
  parameter int rr_p        = 1,
  parameter int lg_width_lp = (width_p == 1) ? 1 : $clog2(width_p)
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bsg_priority_encode_rr_if.slave enc
);

  localparam logic [lg_width_lp-1:0] ptr_reset_lp =
    (lo_to_hi_p != 0) ? {lg_width_lp{1'b0}} : lg_width_lp'(width_p - 1);

  logic [width_p-1:0]     mask_s;
  logic [width_p-1:0]     masked_s;
  logic [width_p-1:0]     m_one_hot_s;
  logic [width_p-1:0]     u_one_hot_s;
  logic [lg_width_lp-1:0] m_addr_s;
  logic [lg_width_lp-1:0] u_addr_s;
  logic                   m_v_s;
  logic                   u_v_s;
  logic [width_p-1:0]     win_one_hot_s;
  logic [lg_width_lp-1:0] win_addr_s;
  logic                   load_s;
  logic [width_p-1:0]     taken_s;
  logic [lg_width_lp-1:0] ptr_next_s;

  logic                   v_r;
  logic [lg_width_lp-1:0] addr_r;
  logic [width_p-1:0]     one_hot_r;
  logic [lg_width_lp-1:0] ptr_r;

  // Keep the requests at or past the pointer in the search direction.
  always_comb begin
    mask_s = {width_p{1'b0}};
    for (int i = 0; i < width_p; i++) begin
      mask_s[i] = (lo_to_hi_p != 0) ? (i >= int'(ptr_r)) : (i <= int'(ptr_r));
    end
    masked_s = enc.reqs_i & mask_s;
  end

  bsg_priority_encode_dir #(
    .width_p    (width_p),
    .lo_to_hi_p (lo_to_hi_p),
    .lg_width_lp(lg_width_lp)
  ) masked_find (
    .vec    (masked_s),
    .one_hot(m_one_hot_s),
    .addr   (m_addr_s),
    .v      (m_v_s)
  );

  bsg_priority_encode_dir #(
    .width_p    (width_p),
    .lo_to_hi_p (lo_to_hi_p),
    .lg_width_lp(lg_width_lp)
  ) unmasked_find (
    .vec    (enc.reqs_i),
    .one_hot(u_one_hot_s),
    .addr   (u_addr_s),
    .v      (u_v_s)
  );

  // Winner select: the unmasked search only matters when nothing lies ahead of the pointer (wrap).
  always_comb begin
    if (m_v_s) begin
      win_one_hot_s = m_one_hot_s;
      win_addr_s    = m_addr_s;
    end else begin
      win_one_hot_s = u_one_hot_s;
      win_addr_s    = u_addr_s;
    end
    load_s = u_v_s & (~v_r | enc.yumi_i);
    if (reset_i) begin
      taken_s = {width_p{1'b0}};
    end else if (load_s) begin
      taken_s = win_one_hot_s;
    end else begin
      taken_s = {width_p{1'b0}};
    end
  end

  // Next start pointer: one step past the winner, wrapping at either end.
  always_comb begin
    if (lo_to_hi_p != 0) begin
      if (win_addr_s == lg_width_lp'(width_p - 1)) begin
        ptr_next_s = {lg_width_lp{1'b0}};
      end else begin
        ptr_next_s = win_addr_s + lg_width_lp'(1'b1);
      end
    end else begin
      if (win_addr_s == {lg_width_lp{1'b0}}) begin
        ptr_next_s = lg_width_lp'(width_p - 1);
      end else begin
        ptr_next_s = win_addr_s - lg_width_lp'(1'b1);
      end
    end
  end

  // Output register: load replaces the held grant, yumi alone just invalidates it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r       <= 1'b0;
      addr_r    <= {lg_width_lp{1'b0}};
      one_hot_r <= {width_p{1'b0}};
    end else if (load_s) begin
      v_r       <= 1'b1;
      addr_r    <= win_addr_s;
      one_hot_r <= win_one_hot_s;
    end else if (enc.yumi_i) begin
      v_r       <= 1'b0;
    end
  end

  // Round-robin pointer; frozen at its reset value in fixed-priority mode.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= ptr_reset_lp;
    end else if ((rr_p != 0) && load_s) begin
      ptr_r <= ptr_next_s;
    end
  end

  assign enc.taken_o   = taken_s;
  assign enc.v_o       = v_r;
  assign enc.addr_o    = addr_r;
  assign enc.one_hot_o = one_hot_r;

  bsg_priority_encode_rr_chk #(.width_p(width_p)) chk (
    .clk  (clk_i),
    .reset(reset_i),
    .reqs (enc.reqs_i),
    .taken(enc.taken_o),
    .v    (enc.v_o),
    .yumi (enc.yumi_i)
  );

endmodule

// File: tb/tb_bsg_priority_encode_rr.sv
// Bench for bsg_priority_encode_rr: five configurations run side by side against a
// circular-search reference model, with directed sequences pinned to literal values.
module tb_bsg_priority_encode_rr;

  logic clk;
  logic rst;

  int n_pass  = 0;
  int n_total = 0;

  int cw  [5] = '{8, 8, 8, 5, 1};
  bit clo [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit crr [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [31:0] reqs_d [5];
  logic        yumi_d [5];
  logic [31:0] taken_a [5];
  logic [31:0] oh_a [5];
  logic [31:0] addr_a [5];
  logic        v_a [5];
  logic [31:0] taken_seen [5];

  bit          mv [5];
  int          maddr [5];
  logic [31:0] mone [5];
  int          mptr [5];

  bsg_priority_encode_rr_if #(.width_p(8)) if0 ();
  bsg_priority_encode_rr_if #(.width_p(8)) if1 ();
  bsg_priority_encode_rr_if #(.width_p(8)) if2 ();
  bsg_priority_encode_rr_if #(.width_p(5)) if3 ();
  bsg_priority_encode_rr_if #(.width_p(1)) if4 ();

  bsg_priority_encode_rr #(.width_p(8), .lo_to_hi_p(1), .rr_p(1)) u0 (.clk_i(clk), .reset_i(rst), .enc(if0));
  bsg_priority_encode_rr #(.width_p(8), .lo_to_hi_p(1), .rr_p(0)) u1 (.clk_i(clk), .reset_i(rst), .enc(if1));
  bsg_priority_encode_rr #(.width_p(8), .lo_to_hi_p(0), .rr_p(1)) u2 (.clk_i(clk), .reset_i(rst), .enc(if2));
  bsg_priority_encode_rr #(.width_p(5), .lo_to_hi_p(1), .rr_p(1)) u3 (.clk_i(clk), .reset_i(rst), .enc(if3));
  bsg_priority_encode_rr #(.width_p(1), .lo_to_hi_p(1), .rr_p(1)) u4 (.clk_i(clk), .reset_i(rst), .enc(if4));

  assign if0.reqs_i = reqs_d[0][7:0];
  assign if1.reqs_i = reqs_d[1][7:0];
  assign if2.reqs_i = reqs_d[2][7:0];
  assign if3.reqs_i = reqs_d[3][4:0];
  assign if4.reqs_i = reqs_d[4][0:0];
  assign if0.yumi_i = yumi_d[0];
  assign if1.yumi_i = yumi_d[1];
  assign if2.yumi_i = yumi_d[2];
  assign if3.yumi_i = yumi_d[3];
  assign if4.yumi_i = yumi_d[4];

  assign taken_a[0] = 32'(if0.taken_o);
  assign taken_a[1] = 32'(if1.taken_o);
  assign taken_a[2] = 32'(if2.taken_o);
  assign taken_a[3] = 32'(if3.taken_o);
  assign taken_a[4] = 32'(if4.taken_o);
  assign oh_a[0]    = 32'(if0.one_hot_o);
  assign oh_a[1]    = 32'(if1.one_hot_o);
  assign oh_a[2]    = 32'(if2.one_hot_o);
  assign oh_a[3]    = 32'(if3.one_hot_o);
  assign oh_a[4]    = 32'(if4.one_hot_o);
  assign addr_a[0]  = 32'(if0.addr_o);
  assign addr_a[1]  = 32'(if1.addr_o);
  assign addr_a[2]  = 32'(if2.addr_o);
  assign addr_a[3]  = 32'(if3.addr_o);
  assign addr_a[4]  = 32'(if4.addr_o);
  assign v_a[0]     = if0.v_o;
  assign v_a[1]     = if1.v_o;
  assign v_a[2]     = if2.v_o;
  assign v_a[3]     = if3.v_o;
  assign v_a[4]     = if4.v_o;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Circular search starting at the pointer, stepping in the search direction.
  function automatic int find_winner(input logic [31:0] r, input int w, input bit lo, input int ptr);
    for (int k = 0; k < w; k++) begin
      int idx;
      idx = lo ? (ptr + k) % w : (ptr - k + w) % w;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mv[i]    = 1'b0;
      maddr[i] = 0;
      mone[i]  = 32'd0;
      mptr[i]  = clo[i] ? 0 : cw[i] - 1;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s v[%0d]", tag, i), {31'd0, v_a[i]}, {31'd0, mv[i]});
      chk($sformatf("%s addr[%0d]", tag, i), addr_a[i], maddr[i]);
      chk($sformatf("%s one_hot[%0d]", tag, i), oh_a[i], mone[i]);
    end
  endtask

  // One cycle: apply reqs_d/yumi_d (yumi only while a grant is held), check taken, then registers.
  task automatic step();
    for (int i = 0; i < 5; i++) begin
      reqs_d[i] = reqs_d[i] & ((32'd1 << cw[i]) - 32'd1);
      yumi_d[i] = yumi_d[i] & mv[i];
    end
    #1;
    for (int i = 0; i < 5; i++) begin
      int          win;
      bit          load;
      logic [31:0] exp_t;
      win   = find_winner(reqs_d[i], cw[i], clo[i], mptr[i]);
      load  = (win >= 0) && (!mv[i] || yumi_d[i]);
      exp_t = load ? (32'd1 << win) : 32'd0;
      taken_seen[i] = taken_a[i];
      chk($sformatf("taken[%0d]", i), taken_a[i], exp_t);
      if (load) begin
        mv[i]    = 1'b1;
        maddr[i] = win;
        mone[i]  = 32'd1 << win;
        if (crr[i]) mptr[i] = clo[i] ? (win + 1) % cw[i] : (win - 1 + cw[i]) % cw[i];
      end else if (yumi_d[i]) begin
        mv[i] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_regs("reg");
  endtask

  // Reset pulse placed between edges: registers must clear without a clock edge.
  task automatic pulse_reset();
    for (int i = 0; i < 5; i++) yumi_d[i] = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_regs("async_rst");
    for (int i = 0; i < 5; i++) chk($sformatf("rst taken[%0d]", i), taken_a[i], 32'd0);
    for (int i = 0; i < 5; i++) reqs_d[i] = 32'd0;
    #1 rst = 1'b0;
    @(negedge clk);
    check_regs("post_rst");
  endtask

  initial begin
    int e0 [4] = '{1, 4, 7, 1};
    int t0 [4] = '{32'h02, 32'h10, 32'h80, 32'h02};
    int e2 [4] = '{7, 0, 7, 0};
    int e3 [4] = '{3, 0, 1, 0};

    clk = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reqs_d[i] = 32'd0;
      yumi_d[i] = 1'b0;
    end
    @(negedge clk);
    model_reset();
    check_regs("reset");
    #1 rst = 1'b0;

    // Round-robin rotation, fixed priority, descending wrap and width-5 wrap.
    for (int j = 0; j < 4; j++) begin
      reqs_d[0] = 32'h92;
      reqs_d[1] = 32'h92;
      reqs_d[2] = 32'h81;
      reqs_d[3] = (j == 0) ? 32'h08 : 32'h03;
      reqs_d[4] = 32'h01;
      for (int i = 0; i < 5; i++) yumi_d[i] = 1'b1;
      step();
      chk($sformatf("rr taken0 #%0d", j), taken_seen[0], t0[j]);
      chk($sformatf("rr addr0 #%0d", j), addr_a[0], e0[j]);
      chk($sformatf("fixed addr1 #%0d", j), addr_a[1], 32'd1);
      chk($sformatf("desc addr2 #%0d", j), addr_a[2], e2[j]);
      chk($sformatf("w5 addr3 #%0d", j), addr_a[3], e3[j]);
      chk($sformatf("w1 addr4 #%0d", j), addr_a[4], 32'd0);
    end

    // Reset while grants are held, then everything requesting.
    pulse_reset();
    for (int i = 0; i < 5; i++) reqs_d[i] = 32'hFF;
    step();
    chk("post_rst taken0", taken_seen[0], 32'h01);
    chk("post_rst addr0", addr_a[0], 32'd0);

    // Backpressure: grant held for five cycles, then yumi takes the next request in the same cycle.
    pulse_reset();
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 5; i++) begin
        reqs_d[i] = 32'h0C;
        yumi_d[i] = (j == 5);
      end
      step();
      chk($sformatf("bp taken0 #%0d", j), taken_seen[0], (j == 0) ? 32'h04 : ((j == 5) ? 32'h08 : 32'h00));
      chk($sformatf("bp addr0 #%0d", j), addr_a[0], (j == 5) ? 32'd3 : 32'd2);
      chk($sformatf("bp v0 #%0d", j), {31'd0, v_a[0]}, 32'd1);
    end

    // Random traffic with occasional idle cycles, sparse requests and resets.
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < 5; i++) begin
        case ($urandom_range(0, 3))
          0:       reqs_d[i] = 32'd0;
          1:       reqs_d[i] = 32'd1 << $urandom_range(0, 7);
          default: reqs_d[i] = $urandom;
        endcase
        yumi_d[i] = ($urandom_range(0, 2) != 0);
      end
      step();
      if (j % 97 == 96) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
